// File: rtl/i2s_master_rx_if.sv
// i2s_master_rx_if: groups the I2S master receiver control, serial bus and
// received-word signals; master is the receiver side, slave the user side.
interface i2s_master_rx_if #(
  parameter int DATA_W = 16
);
  logic              enable;
  logic              sd_in;
  logic              sck;
  logic              ws;
  logic [DATA_W-1:0] l_data;
  logic [DATA_W-1:0] r_data;
  logic              recv_valid;
  logic              busy;

  modport master (
    input  enable, sd_in,
    output sck, ws, l_data, r_data, recv_valid, busy
  );

  modport slave (
    output enable, sd_in,
    input  sck, ws, l_data, r_data, recv_valid, busy
  );
endinterface

// File: rtl/i2s_master_rx.sv
// i2s_master_rx: I2S bus master receiver. Generates SCK/WS from clk_in and
// collects one left/right word pair per frame from an external slave.
module i2s_master_rx #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2
) (
  input  logic            clk_in,
  input  logic            rstn,
  i2s_master_rx_if.master bus
);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SLOT_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(2 * DATA_W - 1);
  localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(DATA_W);

  typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, STOP} state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [SLOT_W-1:0]   slot;
  logic [SLOT_W-1:0]   slot_next;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   l_hold;
  logic [DATA_W-1:0]   l_data_q;
  logic [DATA_W-1:0]   r_data_q;
  logic                sck_q;
  logic                ws_q;
  logic                recv_valid_q;
  logic                primed;
  logic                abort;
  logic                left_seen;
  logic                cap_left;
  logic                cap_pair;
  logic                tick;
  logic                rise;
  logic                fall;

  assign tick      = (div_cnt == DIV_LAST);
  assign rise      = (state != IDLE) && tick && !sck_q;
  assign fall      = (state != IDLE) && tick && sck_q;
  assign slot_next = (slot == SLOT_LAST) ? '0 : slot + 1'b1;

  // Captures are flagged on the SCK rise and committed one clk_in later, so
  // the word registers load from a shift register that already holds the LSB.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      div_cnt      <= '0;
      slot         <= '0;
      shreg        <= '0;
      l_hold       <= '0;
      l_data_q     <= '0;
      r_data_q     <= '0;
      sck_q        <= 1'b0;
      ws_q         <= 1'b0;
      recv_valid_q <= 1'b0;
      primed       <= 1'b0;
      abort        <= 1'b0;
      left_seen    <= 1'b0;
      cap_left     <= 1'b0;
      cap_pair     <= 1'b0;
    end else begin
      cap_left     <= 1'b0;
      cap_pair     <= 1'b0;
      recv_valid_q <= cap_pair;
      if (cap_left) l_hold <= shreg;
      if (cap_pair) begin
        l_data_q <= l_hold;
        r_data_q <= shreg;
      end

      if (state == IDLE) begin
        div_cnt   <= '0;
        slot      <= '0;
        sck_q     <= 1'b0;
        ws_q      <= 1'b0;
        primed    <= 1'b0;
        abort     <= 1'b0;
        left_seen <= 1'b0;
        if (bus.enable) state <= START;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) sck_q <= !sck_q;
        if (rise) shreg <= {shreg[DATA_W-2:0], bus.sd_in};
        if (fall) begin
          slot <= slot_next;
          ws_q <= (slot_next >= SLOT_RIGHT);
        end
        if (rise && slot == SLOT_RIGHT) begin
          cap_left  <= 1'b1;
          left_seen <= 1'b1;
        end

        // Falls that end the bus also park the slot counter and WS at frame start.
        case (state)
          START: begin
            if (!bus.enable) abort <= 1'b1;
            if (fall) primed <= 1'b1;
            if (rise && slot == '0 && primed && bus.enable && !abort) begin
              state     <= RUN;
              cap_pair  <= 1'b1;
              left_seen <= 1'b0;
            end else if (fall && (abort || !bus.enable)) begin
              state <= IDLE;
              slot  <= '0;
              ws_q  <= 1'b0;
            end
          end
          RUN: begin
            if (rise && slot == '0) cap_pair <= 1'b1;
            if (!bus.enable) state <= DRAIN;
          end
          DRAIN: begin
            if (rise && slot == '0) begin
              cap_pair <= left_seen;
              state    <= bus.enable ? RUN : STOP;
            end else if (bus.enable) begin
              state <= RUN;
            end
          end
          STOP: begin
            if (bus.enable) begin
              state <= RUN;
            end else if (fall) begin
              state <= IDLE;
              slot  <= '0;
              ws_q  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sck        = sck_q;
  assign bus.ws         = ws_q;
  assign bus.l_data     = l_data_q;
  assign bus.r_data     = r_data_q;
  assign bus.recv_valid = recv_valid_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_i2s_master_rx.sv
// tb_i2s_master_rx: drives two receivers (16-bit/div 2 and 24-bit/div 1) from
// behavioural I2S slave transmitters and checks words and pulse timing.
module tb_i2s_master_rx;
  logic clk_in = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mode = 0;
  int   a_pulses = 0;
  int   b_pulses = 0;

  i2s_master_rx_if #(.DATA_W(16)) a_if();
  i2s_master_rx_if #(.DATA_W(24)) b_if();

  i2s_master_rx #(.DATA_W(16), .CLK_DIV(2)) dut_a (
    .clk_in (clk_in),
    .rstn   (rstn),
    .bus    (a_if.master)
  );

  i2s_master_rx #(.DATA_W(24), .CLK_DIV(1)) dut_b (
    .clk_in (clk_in),
    .rstn   (rstn),
    .bus    (b_if.master)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (a_if.recv_valid === 1'b1) a_pulses++;
    if (b_if.recv_valid === 1'b1) b_pulses++;
  end

  // Slave transmitter A: changes data after each SCK fall, word MSB one SCK
  // after the WS edge; records every pair it starts sending.
  logic [31:0] a_sent_l [64];
  logic [31:0] a_sent_r [64];
  int          a_sent_n = 0;
  logic [15:0] a_tx;
  logic [31:0] a_l, a_r, a_cur_r;
  logic        a_reload, a_left_next, a_sck_prev, a_ws_prev;

  always @(posedge clk_in) begin
    #1;
    if (a_if.busy !== 1'b1) begin
      a_reload    = 1'b1;
      a_left_next = 1'b1;
      a_sent_n    = 0;
      a_sck_prev  = 1'b0;
      a_ws_prev   = 1'b0;
      a_if.sd_in  = 1'($urandom);
    end else begin
      if (a_sck_prev && !a_if.sck) begin
        if (a_reload) begin
          if (a_left_next) begin
            case (mode)
              0: begin a_l = 32'hA5A5; a_r = 32'h5A5A; end
              1: begin
                if (a_sent_n % 2 == 0) begin a_l = 32'hFFFF; a_r = 32'h0000; end
                else begin a_l = 32'h0001; a_r = 32'h8000; end
              end
              default: begin a_l = $urandom & 32'hFFFF; a_r = $urandom & 32'hFFFF; end
            endcase
            if (a_sent_n < 64) begin
              a_sent_l[a_sent_n] = a_l;
              a_sent_r[a_sent_n] = a_r;
            end
            a_sent_n++;
            a_cur_r = a_r;
            a_tx    = a_l[15:0];
          end else begin
            a_tx = a_cur_r[15:0];
          end
          a_reload = 1'b0;
        end
        a_if.sd_in = a_tx[15];
        a_tx       = a_tx << 1;
        if (a_if.ws !== a_ws_prev) begin
          a_reload    = 1'b1;
          a_left_next = !a_if.ws;
        end
        a_ws_prev = a_if.ws;
      end
      a_sck_prev = a_if.sck;
    end
  end

  // Slave transmitter B: same protocol, random 24-bit words.
  logic [31:0] b_sent_l [64];
  logic [31:0] b_sent_r [64];
  int          b_sent_n = 0;
  logic [23:0] b_tx;
  logic [31:0] b_l, b_r, b_cur_r;
  logic        b_reload, b_left_next, b_sck_prev, b_ws_prev;

  always @(posedge clk_in) begin
    #1;
    if (b_if.busy !== 1'b1) begin
      b_reload    = 1'b1;
      b_left_next = 1'b1;
      b_sent_n    = 0;
      b_sck_prev  = 1'b0;
      b_ws_prev   = 1'b0;
      b_if.sd_in  = 1'($urandom);
    end else begin
      if (b_sck_prev && !b_if.sck) begin
        if (b_reload) begin
          if (b_left_next) begin
            b_l = $urandom & 32'hFF_FFFF;
            b_r = $urandom & 32'hFF_FFFF;
            if (b_sent_n < 64) begin
              b_sent_l[b_sent_n] = b_l;
              b_sent_r[b_sent_n] = b_r;
            end
            b_sent_n++;
            b_cur_r = b_r;
            b_tx    = b_l[23:0];
          end else begin
            b_tx = b_cur_r[23:0];
          end
          b_reload = 1'b0;
        end
        b_if.sd_in = b_tx[23];
        b_tx       = b_tx << 1;
        if (b_if.ws !== b_ws_prev) begin
          b_reload    = 1'b1;
          b_left_next = !b_if.ws;
        end
        b_ws_prev = b_if.ws;
      end
      b_sck_prev = b_if.sck;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_pulse_a(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(posedge clk_in); #1;
      if (a_if.recv_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic wait_pulse_b(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(posedge clk_in); #1;
      if (b_if.recv_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic apply_reset();
    step(1);
    a_if.enable = 1'b0;
    b_if.enable = 1'b0;
    rstn = 1'b0;
    step(3);
    rstn = 1'b1;
    step(2);
  endtask

  task automatic test_reset();
    int sck_hi = 0;
    step(1);
    rstn = 1'b0;
    a_if.enable = 1'b1;
    b_if.enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (a_if.sck !== 1'b0 || b_if.sck !== 1'b0) sck_hi++;
    end
    n_cmp++;
    if (sck_hi !== 0) begin
      n_err++;
      $display("[TB] FAIL reset_sck_static: sck high on %0d cycles, expected 0", sck_hi);
    end
    n_cmp++;
    if ({a_if.sck, a_if.ws, a_if.recv_valid, a_if.busy, a_if.l_data, a_if.r_data} !== 36'h0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs_a: got %h expected 0",
               {a_if.sck, a_if.ws, a_if.recv_valid, a_if.busy, a_if.l_data, a_if.r_data});
    end
    n_cmp++;
    if ({b_if.sck, b_if.ws, b_if.recv_valid, b_if.busy, b_if.l_data, b_if.r_data} !== 52'h0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs_b: got %h expected 0",
               {b_if.sck, b_if.ws, b_if.recv_valid, b_if.busy, b_if.l_data, b_if.r_data});
    end
    a_if.enable = 1'b0;
    b_if.enable = 1'b0;
    rstn = 1'b1;
    step(2);
  endtask

  task automatic test_fixed_words();
    bit got;
    int t0;
    apply_reset();
    mode = 0;
    a_if.enable = 1'b1;
    t0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      wait_pulse_a(300, got);
      n_cmp++;
      if (!got || cyc !== t0 + 131 + 128 * k) begin
        n_err++;
        $display("[TB] FAIL fixed_pulse_cycle[%0d]: got %0d (seen %0d) expected %0d",
                 k, cyc - t0, got, 131 + 128 * k);
      end
      n_cmp++;
      if (a_if.l_data !== 16'hA5A5 || a_if.r_data !== 16'h5A5A) begin
        n_err++;
        $display("[TB] FAIL fixed_words[%0d]: got %h/%h expected a5a5/5a5a",
                 k, a_if.l_data, a_if.r_data);
      end
    end
  endtask

  task automatic test_alternating();
    bit got;
    int ws_hi;
    logic [15:0] exp_l, exp_r;
    apply_reset();
    mode = 1;
    a_if.enable = 1'b1;
    wait_pulse_a(300, got);
    n_cmp++;
    if (!got || a_if.l_data !== 16'hFFFF || a_if.r_data !== 16'h0000) begin
      n_err++;
      $display("[TB] FAIL alt_words[0]: got %h/%h (seen %0d) expected ffff/0000",
               a_if.l_data, a_if.r_data, got);
    end
    for (int k = 1; k < 3; k++) begin
      ws_hi = 0;
      for (int i = 0; i < 128; i++) begin
        step(1);
        if (a_if.ws === 1'b1) ws_hi++;
      end
      exp_l = (k % 2 == 1) ? 16'h0001 : 16'hFFFF;
      exp_r = (k % 2 == 1) ? 16'h8000 : 16'h0000;
      n_cmp++;
      if (ws_hi !== 64) begin
        n_err++;
        $display("[TB] FAIL alt_ws_high[%0d]: got %0d cycles expected 64", k, ws_hi);
      end
      n_cmp++;
      if (a_if.recv_valid !== 1'b1 || a_if.l_data !== exp_l || a_if.r_data !== exp_r) begin
        n_err++;
        $display("[TB] FAIL alt_words[%0d]: got v=%b %h/%h expected v=1 %h/%h",
                 k, a_if.recv_valid, a_if.l_data, a_if.r_data, exp_l, exp_r);
      end
    end
  endtask

  task automatic test_drain();
    bit got;
    int t0, pp, cnt;
    apply_reset();
    mode = 2;
    a_if.enable = 1'b1;
    t0 = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      wait_pulse_a(300, got);
      n_cmp++;
      if (!got || a_if.l_data !== a_sent_l[k][15:0] || a_if.r_data !== a_sent_r[k][15:0]) begin
        n_err++;
        $display("[TB] FAIL drain_run_words[%0d]: got %h/%h expected %h/%h",
                 k, a_if.l_data, a_if.r_data, a_sent_l[k][15:0], a_sent_r[k][15:0]);
      end
    end
    pp = cyc;
    for (int i = 0; i < 200 && a_if.ws !== 1'b1; i++) step(1);
    step(8);
    a_if.enable = 1'b0;
    wait_pulse_a(200, got);
    n_cmp++;
    if (!got || cyc !== pp + 128) begin
      n_err++;
      $display("[TB] FAIL drain_pulse_cycle: got %0d (seen %0d) expected %0d", cyc - pp, got, 128);
    end
    n_cmp++;
    if (a_if.l_data !== a_sent_l[2][15:0] || a_if.r_data !== a_sent_r[2][15:0]) begin
      n_err++;
      $display("[TB] FAIL drain_words: got %h/%h expected %h/%h",
               a_if.l_data, a_if.r_data, a_sent_l[2][15:0], a_sent_r[2][15:0]);
    end
    step(4);
    n_cmp++;
    if ({a_if.sck, a_if.ws, a_if.busy} !== 3'b000) begin
      n_err++;
      $display("[TB] FAIL drain_idle: got sck/ws/busy=%b expected 000", {a_if.sck, a_if.ws, a_if.busy});
    end
    cnt = a_pulses;
    step(300);
    n_cmp++;
    if (a_pulses !== cnt) begin
      n_err++;
      $display("[TB] FAIL drain_extra_pulses: got %0d expected 0", a_pulses - cnt);
    end
    a_if.enable = 1'b1;
    t0 = cyc + 1;
    wait_pulse_a(400, got);
    n_cmp++;
    if (!got || cyc !== t0 + 131) begin
      n_err++;
      $display("[TB] FAIL reenable_pulse_cycle: got %0d (seen %0d) expected 131", cyc - t0, got);
    end
    n_cmp++;
    if (a_if.l_data !== a_sent_l[0][15:0] || a_if.r_data !== a_sent_r[0][15:0]) begin
      n_err++;
      $display("[TB] FAIL reenable_words: got %h/%h expected %h/%h",
               a_if.l_data, a_if.r_data, a_sent_l[0][15:0], a_sent_r[0][15:0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit got;
    int t0;
    apply_reset();
    mode = 2;
    a_if.enable = 1'b1;
    wait_pulse_a(300, got);
    step(20);
    n_cmp++;
    if (a_if.ws !== 1'b0 || a_if.busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL midframe_left_half: got ws/busy=%b%b expected 01", a_if.ws, a_if.busy);
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({a_if.sck, a_if.ws, a_if.recv_valid, a_if.busy, a_if.l_data, a_if.r_data} !== 36'h0) begin
      n_err++;
      $display("[TB] FAIL midframe_reset_outputs: got %h expected 0",
               {a_if.sck, a_if.ws, a_if.recv_valid, a_if.busy, a_if.l_data, a_if.r_data});
    end
    step(3);
    rstn = 1'b1;
    t0 = cyc + 1;
    wait_pulse_a(400, got);
    n_cmp++;
    if (!got || cyc !== t0 + 131) begin
      n_err++;
      $display("[TB] FAIL after_reset_pulse_cycle: got %0d (seen %0d) expected 131", cyc - t0, got);
    end
    n_cmp++;
    if (a_if.l_data !== a_sent_l[0][15:0] || a_if.r_data !== a_sent_r[0][15:0]) begin
      n_err++;
      $display("[TB] FAIL after_reset_words: got %h/%h expected %h/%h",
               a_if.l_data, a_if.r_data, a_sent_l[0][15:0], a_sent_r[0][15:0]);
    end
  endtask

  task automatic test_param_sweep();
    bit got;
    int t0, prev, base;
    apply_reset();
    base = b_pulses;
    b_if.enable = 1'b1;
    t0 = cyc + 1;
    prev = t0 + 98 - 96;
    for (int k = 0; k < 20; k++) begin
      wait_pulse_b(200, got);
      n_cmp++;
      if (!got || cyc !== prev + 96) begin
        n_err++;
        $display("[TB] FAIL sweep_pulse_cycle[%0d]: got %0d (seen %0d) expected %0d",
                 k, cyc - t0, got, prev + 96 - t0);
      end
      prev = prev + 96;
      n_cmp++;
      if (b_if.l_data !== b_sent_l[k][23:0] || b_if.r_data !== b_sent_r[k][23:0]) begin
        n_err++;
        $display("[TB] FAIL sweep_words[%0d]: got %h/%h expected %h/%h",
                 k, b_if.l_data, b_if.r_data, b_sent_l[k][23:0], b_sent_r[k][23:0]);
      end
    end
    step(1);
    n_cmp++;
    if (b_pulses - base !== 20) begin
      n_err++;
      $display("[TB] FAIL sweep_pulse_count: got %0d expected 20", b_pulses - base);
    end
    b_if.enable = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    a_if.enable = 1'b0;
    b_if.enable = 1'b0;
    test_reset();
    test_fixed_words();
    test_alternating();
    test_drain();
    test_reset_mid_frame();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
